// File: rtl/jtag_user_pkg.sv
// Shared definitions for the ECP5 JTAGG user data register controller.
package jtag_user_pkg;

    // JTAG instructions that select the two user data registers.
    localparam logic [7:0] ER1_OPCODE = 8'h32;
    localparam logic [7:0] ER2_OPCODE = 8'h38;

    // Controller state.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEL1  = 2'd1,
        ST_SEL2  = 2'd2,
        ST_HOLD1 = 2'd3
    } dr_state_e;

    // Layout of the ER2 capture word.
    localparam int ER2_RESP_VALID_BIT = 0;
    localparam int ER2_OVERFLOW_BIT   = 1;
    localparam int ER2_RESP_LSB       = 2;

    // Index of each raw JTAGG input in the synchroniser bank.
    localparam int J_TCK    = 0;
    localparam int J_TDI    = 1;
    localparam int J_SHIFT  = 2;
    localparam int J_UPDATE = 3;
    localparam int J_RSTN   = 4;
    localparam int J_CE1    = 5;
    localparam int J_CE2    = 6;
    localparam int J_COUNT  = 7;

endpackage

// File: rtl/jtag_sync_edge.sv
// Multi-flop synchroniser for one JTAGG signal with a rising-edge pulse output.
module jtag_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    // Next values of the synchroniser chain and the edge-detect history flop.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // Register the chain; everything clears on reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign dout = sync_q[SYNC_STAGES-1];
    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/jtag_user_dr_ctrl.sv
// System-clock controller for the ECP5 user DRs ER1 (command in) and ER2
// (response/status out), bridging to a valid/ready command interface.
//
// state    | meaning
// ---------+------------------------------------------
// ST_IDLE  | no user DR active
// ST_SEL1  | ER1 capture/shift in progress
// ST_SEL2  | ER2 capture/shift in progress
// ST_HOLD1 | ER1 update seen, command pending
module jtag_user_dr_ctrl
    import jtag_user_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  jtck,
    input  logic                  jtdi,
    input  logic                  jshift,
    input  logic                  jupdate,
    input  logic                  jrstn,
    input  logic                  jce1,
    input  logic                  jce2,
    output logic                  jtdo1,
    output logic                  jtdo2,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [DATA_WIDTH-1:0] cmd_data,
    input  logic                  rsp_valid,
    input  logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  overflow
);

    logic [J_COUNT-1:0] j_raw, j_sync, j_rise;
    logic [4:0]         unused_rise;

    assign j_raw = {jce2, jce1, jrstn, jupdate, jshift, jtdi, jtck};

    for (genvar gi = 0; gi < J_COUNT; gi++) begin : g_sync
        jtag_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clock (clock),
            .reset (reset),
            .din   (j_raw[gi]),
            .dout  (j_sync[gi]),
            .rise  (j_rise[gi])
        );
    end

    // Only JTCK and JUPDATE need edge detection; the rest are level signals.
    assign unused_rise = {j_rise[J_CE2], j_rise[J_CE1], j_rise[J_RSTN],
                          j_rise[J_SHIFT], j_rise[J_TDI]};

    logic tck_rise, upd_rise, tdi_s, shift_s, rstn_s, ce1_s, ce2_s, handshake;

    assign tck_rise  = j_rise[J_TCK];
    assign upd_rise  = j_rise[J_UPDATE];
    assign tdi_s     = j_sync[J_TDI];
    assign shift_s   = j_sync[J_SHIFT];
    assign rstn_s    = j_sync[J_RSTN];
    assign ce1_s     = j_sync[J_CE1];
    assign ce2_s     = j_sync[J_CE2];
    assign handshake = cmd_valid_q & cmd_ready;

    dr_state_e               state_q, state_d;
    logic [DATA_WIDTH-1:0]   er1_q, er1_d;
    logic [DATA_WIDTH+1:0]   er2_q, er2_d;
    logic [DATA_WIDTH-1:0]   resp_q, resp_d;
    logic [DATA_WIDTH-1:0]   cmd_data_q, cmd_data_d;
    logic                    resp_valid_q, resp_valid_d;
    logic                    cmd_valid_q, cmd_valid_d;
    logic                    overflow_q, overflow_d;
    logic                    jtdo1_q, jtdo1_d;
    logic                    jtdo2_q, jtdo2_d;

    // Next-state logic: TAP reset, then capture/shift (ER1 wins a double
    // select), then update; responses are applied last so a response landing
    // on an ER2 capture leaves the flag set.
    always_comb begin
        state_d      = state_q;
        er1_d        = er1_q;
        er2_d        = er2_q;
        resp_d       = resp_q;
        resp_valid_d = resp_valid_q;
        cmd_valid_d  = cmd_valid_q;
        cmd_data_d   = cmd_data_q;
        overflow_d   = overflow_q;
        jtdo1_d      = jtdo1_q;
        jtdo2_d      = jtdo2_q;

        if (handshake) begin
            cmd_valid_d = 1'b0;
            if (state_q == ST_HOLD1) begin
                state_d = ST_IDLE;
            end
        end

        if (!rstn_s) begin
            // TAP reset clears the scan side only; a pending command survives.
            er1_d   = '0;
            er2_d   = '0;
            state_d = ST_IDLE;
            jtdo1_d = 1'b0;
            jtdo2_d = 1'b0;
        end else if (tck_rise && ce1_s) begin
            state_d = ST_SEL1;
            er1_d   = shift_s ? {tdi_s, er1_q[DATA_WIDTH-1:1]} : '0;
            jtdo1_d = er1_d[0];
        end else if (tck_rise && ce2_s) begin
            state_d = ST_SEL2;
            if (shift_s) begin
                er2_d = {tdi_s, er2_q[DATA_WIDTH+1:1]};
            end else begin
                er2_d[DATA_WIDTH+1:ER2_RESP_LSB] = resp_q;
                er2_d[ER2_OVERFLOW_BIT]          = overflow_q;
                er2_d[ER2_RESP_VALID_BIT]        = resp_valid_q;
                resp_valid_d                     = 1'b0;
            end
            jtdo2_d = er2_d[0];
        end else if (upd_rise && (state_q == ST_SEL1 || state_q == ST_SEL2)) begin
            if (state_q == ST_SEL1) begin
                if (!cmd_valid_q || handshake) begin
                    cmd_data_d  = er1_q;
                    cmd_valid_d = 1'b1;
                end else begin
                    overflow_d = 1'b1;
                end
            end else if (er2_q[0]) begin
                overflow_d = 1'b0;
            end
            state_d = cmd_valid_d ? ST_HOLD1 : ST_IDLE;
        end

        if (rsp_valid) begin
            resp_d       = rsp_data;
            resp_valid_d = 1'b1;
        end
    end

    // All controller state, including the registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            er1_q        <= '0;
            er2_q        <= '0;
            resp_q       <= '0;
            resp_valid_q <= 1'b0;
            cmd_valid_q  <= 1'b0;
            cmd_data_q   <= '0;
            overflow_q   <= 1'b0;
            jtdo1_q      <= 1'b0;
            jtdo2_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            er1_q        <= er1_d;
            er2_q        <= er2_d;
            resp_q       <= resp_d;
            resp_valid_q <= resp_valid_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_data_q   <= cmd_data_d;
            overflow_q   <= overflow_d;
            jtdo1_q      <= jtdo1_d;
            jtdo2_q      <= jtdo2_d;
        end
    end

    assign jtdo1     = jtdo1_q;
    assign jtdo2     = jtdo2_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_data  = cmd_data_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_jtag_user_dr_ctrl.sv
// Directed bench for jtag_user_dr_ctrl with hand-computed expectations.
module tb_jtag_user_dr_ctrl;
    import jtag_user_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        jtck = 1'b0, jtdi = 1'b0, jshift = 1'b0, jupdate = 1'b0;
    logic        jrstn = 1'b1, jce1 = 1'b0, jce2 = 1'b0;
    logic        jtdo1, jtdo2, cmd_valid, overflow;
    logic        cmd_ready = 1'b0;
    logic [31:0] cmd_data;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = '0;

    int errors = 0;
    int checks = 0;

    jtag_user_dr_ctrl #(.DATA_WIDTH(32), .SYNC_STAGES(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .jtck      (jtck),
        .jtdi      (jtdi),
        .jshift    (jshift),
        .jupdate   (jupdate),
        .jrstn     (jrstn),
        .jce1      (jce1),
        .jce2      (jce2),
        .jtdo1     (jtdo1),
        .jtdo2     (jtdo2),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // One JTCK period, slow enough for the synchroniser; ends with JTCK high
    // after the rising edge has been acted on.
    task automatic tck_pulse(input logic tdi);
        jtdi = tdi;
        jtck = 1'b0;
        cyc(4);
        jtck = 1'b1;
        cyc(5);
    endtask

    task automatic scan_er1(input logic [31:0] d, output logic tdo_cap, output logic tdo_last);
        jce1 = 1'b1;
        jshift = 1'b0;
        tck_pulse(1'b0);
        tdo_cap = jtdo1;
        jshift = 1'b1;
        for (int i = 0; i < 32; i++) tck_pulse(d[i]);
        tdo_last = jtdo1;
        jshift = 1'b0;
        jce1 = 1'b0;
        jtck = 1'b0;
        cyc(4);
    endtask

    task automatic scan_er2(input logic [33:0] d, output logic [33:0] tdo);
        tdo = '0;
        jce2 = 1'b1;
        jshift = 1'b0;
        tck_pulse(1'b0);
        tdo[0] = jtdo2;
        jshift = 1'b1;
        for (int i = 0; i < 34; i++) begin
            tck_pulse(d[i]);
            if (i < 33) tdo[i+1] = jtdo2;
        end
        jshift = 1'b0;
        jce2 = 1'b0;
        jtck = 1'b0;
        cyc(4);
    endtask

    task automatic do_update(output int hi, output logic [31:0] seen);
        hi = 0;
        seen = '0;
        jupdate = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (cmd_valid) begin
                hi++;
                seen = cmd_data;
            end
        end
        jupdate = 1'b0;
        cyc(4);
    endtask

    initial begin
        logic        cap, last;
        logic [33:0] stream;
        int          hi;
        logic [31:0] seen;

        // Power-up reset
        cyc(3);
        reset = 1'b0;
        cyc(4);
        check("rst_jtdo1", 64'(jtdo1), 64'd0);
        check("rst_jtdo2", 64'(jtdo2), 64'd0);
        check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        check("rst_cmd_data", 64'(cmd_data), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_state", 64'(dut.state_q), 64'(ST_IDLE));

        // ER1 command accepted immediately
        cmd_ready = 1'b1;
        scan_er1(32'hDEADBEEF, cap, last);
        check("er1_capture_tdo", 64'(cap), 64'd0);
        do_update(hi, seen);
        check("cmd_one_cycle", 64'(hi), 64'd1);
        check("cmd_data_beef", 64'(seen), 64'hDEADBEEF);
        check("cmd_valid_gone", 64'(cmd_valid), 64'd0);
        check("no_overflow_1", 64'(overflow), 64'd0);

        // Back-to-back commands with the sink stalled
        cmd_ready = 1'b0;
        scan_er1(32'h1, cap, last);
        do_update(hi, seen);
        check("first_cmd_valid", 64'(cmd_valid), 64'd1);
        check("first_cmd_data", 64'(cmd_data), 64'h1);
        check("first_no_ovf", 64'(overflow), 64'd0);
        scan_er1(32'h2, cap, last);
        do_update(hi, seen);
        check("drop_keeps_data", 64'(cmd_data), 64'h1);
        check("drop_sets_ovf", 64'(overflow), 64'd1);

        // ER2 shows overflow, shifting in bit0=1 clears it
        scan_er2(34'h1, stream);
        check("er2_ovf_stream", 64'(stream), 64'h2);
        do_update(hi, seen);
        check("ovf_cleared", 64'(overflow), 64'd0);
        check("cmd_still_pending", 64'(cmd_valid), 64'd1);

        // Response readback through ER2
        rsp_data = 32'h12345678;
        rsp_valid = 1'b1;
        cyc(1);
        rsp_valid = 1'b0;
        rsp_data = '0;
        cyc(1);
        scan_er2(34'h0, stream);
        check("er2_rsp_bit0", 64'(stream[0]), 64'd1);
        check("er2_rsp_bit1", 64'(stream[1]), 64'd0);
        check("er2_rsp_stream", 64'(stream), 64'h48D159E1);
        do_update(hi, seen);
        check("er2_bit0_zero_noop", 64'(overflow), 64'd0);
        scan_er2(34'h0, stream);
        check("er2_flag_cleared", 64'(stream), 64'h48D159E0);

        // TAP reset in the middle of an ER1 shift with a command pending
        jce1 = 1'b1;
        jshift = 1'b0;
        tck_pulse(1'b0);
        jshift = 1'b1;
        for (int i = 0; i < 32; i++) tck_pulse(1'b1);
        check("er1_ones_tdo", 64'(jtdo1), 64'd1);
        jrstn = 1'b0;
        cyc(5);
        check("tap_rst_jtdo1", 64'(jtdo1), 64'd0);
        check("tap_rst_er1", 64'(dut.er1_q), 64'd0);
        check("tap_rst_state", 64'(dut.state_q), 64'(ST_IDLE));
        check("tap_rst_cmd_valid", 64'(cmd_valid), 64'd1);
        check("tap_rst_cmd_data", 64'(cmd_data), 64'h1);
        jrstn = 1'b1;
        jshift = 1'b0;
        jce1 = 1'b0;
        jtck = 1'b0;
        cyc(5);
        do_update(hi, seen);
        check("idle_update_data", 64'(cmd_data), 64'h1);
        check("idle_update_ovf", 64'(overflow), 64'd0);

        // Update coinciding with the handshake of the pending command
        scan_er1(32'hA5A50F0F, cap, last);
        jupdate = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1 cmd_ready = 1'b1;
        @(posedge clock);
        #1 cmd_ready = 1'b0;
        cyc(1);
        check("coinc_cmd_valid", 64'(cmd_valid), 64'd1);
        check("coinc_cmd_data", 64'(cmd_data), 64'hA5A50F0F);
        check("coinc_no_ovf", 64'(overflow), 64'd0);
        jupdate = 1'b0;
        cyc(4);
        check("coinc_still_valid", 64'(cmd_valid), 64'd1);

        // Synchronous reset mid-shift with a command pending
        jce1 = 1'b1;
        jshift = 1'b0;
        tck_pulse(1'b0);
        jshift = 1'b1;
        for (int i = 0; i < 32; i++) tck_pulse(1'b1);
        check("pre_rst_jtdo1", 64'(jtdo1), 64'd1);
        reset = 1'b1;
        cyc(1);
        check("mid_rst_jtdo1", 64'(jtdo1), 64'd0);
        check("mid_rst_jtdo2", 64'(jtdo2), 64'd0);
        check("mid_rst_cmd_valid", 64'(cmd_valid), 64'd0);
        check("mid_rst_cmd_data", 64'(cmd_data), 64'd0);
        check("mid_rst_overflow", 64'(overflow), 64'd0);
        check("mid_rst_state", 64'(dut.state_q), 64'(ST_IDLE));
        reset = 1'b0;
        jce1 = 1'b0;
        jshift = 1'b0;
        jtck = 1'b0;
        cyc(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/jtag_user_dr_ctrl.md
Name: jtag_user_dr_ctrl

Overview:
- System-clock-side controller for the ECP5 JTAGG user data registers ER1 (instruction 0x32) and ER2 (instruction 0x38).
- Synchronises the raw JTAGG strobes into `clock`, runs the capture/shift/update sequence for both user DRs and drives JTDO1/JTDO2.
- Turns an ER1 update into a command word on a valid/ready interface to the system fabric.
- Returns system responses and sticky status through ER2, so OpenOCD can drive board logic over the FPGA's own TAP.

Parameters:
- DATA_WIDTH, 32, width of ER1 command word and of response data.
- SYNC_STAGES, 2, flip-flop depth of each JTAG-to-clock synchroniser (minimum 2).

Ports:
- clock  in  1  system clock; must run at least 4x JTCK.
- reset  in  1  synchronous, active-high.
- jtck  in  1  JTAGG JTCK.
- jtdi  in  1  JTAGG JTDI.
- jshift  in  1  JTAGG JSHIFT.
- jupdate  in  1  JTAGG JUPDATE.
- jrstn  in  1  JTAGG JRSTN, active-low TAP reset.
- jce1  in  1  JTAGG JCE1, ER1 selected.
- jce2  in  1  JTAGG JCE2, ER2 selected.
- jtdo1  out  1  to JTAGG JTDO1.
- jtdo2  out  1  to JTAGG JTDO2.
- cmd_valid  out  1  command word available.
- cmd_ready  in  1  system accepts command.
- cmd_data  out  DATA_WIDTH  command word.
- rsp_valid  in  1  single-cycle response strobe; always accepted.
- rsp_data  in  DATA_WIDTH  response word.
- overflow  out  1  sticky: an ER1 update was dropped.

Behaviour:
- Interface: one clock, `clock`. Reset `reset` is synchronous and active-high.
- Reset values: all outputs 0; both shift registers 0; response register 0; resp_valid flag 0; FSM in IDLE.
- Synchronisers:
  - All seven JTAG inputs pass through SYNC_STAGES flops.
  - tck_rise = sync jtck 0->1.
  - upd_rise = sync jupdate 0->1.
  - Sampled jtdi is the synchronised value at tck_rise.
- FSM states:
  - IDLE: no user DR active.
  - SEL1: ER1 capture/shift.
  - SEL2: ER2 capture/shift.
  - HOLD1: ER1 update seen, command pending.
- Capture, on tck_rise with jceN=1 and jshift=0:
  - ER1 loads 0.
  - ER2 (width DATA_WIDTH+2) loads {resp_reg, overflow, resp_valid_flag}.
  - ER2 capture clears resp_valid_flag in the same cycle.
- Shift, on tck_rise with jceN=1 and jshift=1:
  - Register shifts right; MSB <= jtdi.
  - jtdoN is registered from the register's LSB and is updated after every capture and shift.
  - LSB-first on the wire.
- Update, on upd_rise:
  - Last selected ER1, cmd_valid=0: cmd_data <= ER1 shift reg; cmd_valid <= 1 on the next cycle.
  - Last selected ER1, cmd_valid=1: the update is dropped, overflow <= 1, and cmd_data is unchanged.
  - Last selected ER2, shifted-in bit0=1: clears overflow.
  - Last selected ER2, shifted-in bit0=0: no effect.
- Command handshake:
  - cmd_valid and cmd_data stay stable until the cycle with cmd_valid & cmd_ready.
  - cmd_valid falls in the cycle after that handshake.
  - An upd_rise in the same cycle as the handshake counts as not-pending: the new command is accepted, not dropped.
- Responses:
  - rsp_valid loads resp_reg and sets resp_valid_flag. A newer response overwrites an unread one.
  - rsp_valid in the same cycle as an ER2 capture: the old resp_reg goes to the shift register, the new value is stored, and resp_valid_flag ends at 1.
- TAP reset, sync jrstn=0:
  - Shift registers clear; FSM goes to IDLE; jtdo1/jtdo2 go to 0.
  - A pending cmd_valid/cmd_data is kept; overflow is kept.
- Edges with jce1=jce2=0 are ignored.
- If jce1 and jce2 are both 1, which is illegal, ER1 takes priority.

Decomposition:
- Shared package jtag_user_pkg:
  - ER1_OPCODE = 8'h32, ER2_OPCODE = 8'h38.
  - FSM state enum.
  - Status bit indices: ER2 bit0 = resp_valid, bit1 = overflow, bits [DATA_WIDTH+1:2] = response.
- Sub-module jtag_sync_edge: parameterised SYNC_STAGES synchroniser with rise-detect output, instantiated per input.

Test Plan:
- Reset asserted mid-shift with cmd_valid=1 -> next cycle all outputs 0, FSM IDLE, cmd_valid 0.
- ER1 shift of 32'hDEADBEEF LSB-first, then update, cmd_ready=1 -> one-cycle cmd_valid with cmd_data=32'hDEADBEEF; overflow stays 0.
- Two ER1 updates (0x1, then 0x2) with cmd_ready=0 -> cmd_data stays 0x1 and overflow=1. ER2 scan shifting in bit0=1 then update -> overflow=0.
- rsp_valid with 32'h12345678, then ER2 capture+shift -> jtdo2 stream (LSB first) = 1 (resp_valid), 0 (overflow), then 32'h12345678; a second ER2 capture shows bit0=0.
- jrstn pulse low during an ER1 shift with cmd_valid=1 -> shift register cleared, jtdo1=0, cmd_valid and cmd_data retained.
- upd_rise in the same cycle as a cmd handshake -> new command presented next cycle; overflow stays 0.
